move_seq: RTL and testbench
===========================

MOVE_SEQ -- requirements
Module: move_seq

Interface
REQ-001 Parameter DEPTH, default 8, command queue depth; power of two, minimum 2.
REQ-002 Parameter TMO_CYC, default 30000000, maximum cycles from snd_cmd to resp_rdy before a command is declared failed.
REQ-003 Parameter CMD_W, default 16, command width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 push  input  1  enqueue push_cmd this cycle.
REQ-007 push_cmd  input  CMD_W  command word to enqueue.
REQ-008 start  input  1  begin issuing queued commands.
REQ-009 clr_stat  input  1  clear counters and sticky flags.
REQ-010 cmd  output  CMD_W  command presented to the RemoteComm cmd port.
REQ-011 snd_cmd  output  1  one-cycle send strobe to RemoteComm.
REQ-012 cmd_snt  input  1  RemoteComm reports the command is fully transmitted.
REQ-013 resp_rdy  input  1  response byte valid.
REQ-014 resp  input  8  response byte.
REQ-015 full, empty  output  1 each  queue status.
REQ-016 busy, done  output  1 each  sequence running / sequence complete.
REQ-017 pass_cnt, fail_cnt  output  $clog2(DEPTH+1)+8 each  saturating acknowledge tallies.
REQ-018 tmo_err, ovf_err  output  1 each  sticky timeout flag and sticky push-overflow flag.
REQ-019 last_resp  output  8  most recent response byte captured.

Function
REQ-020 The block SHALL use the states IDLE, SEND, WAIT_SNT, WAIT_RESP and DONE.
REQ-021 IDLE: start with empty low SHALL move to SEND on the next edge; start with empty high SHALL be ignored.
REQ-022 SEND: the block SHALL drive cmd equal to the queue head, assert snd_cmd for exactly one cycle, pop the head, and move to WAIT_SNT.
REQ-023 cmd SHALL hold its value until the next SEND.
REQ-024 WAIT_SNT: the block SHALL move to WAIT_RESP on cmd_snt.
REQ-025 WAIT_RESP: resp_rdy with resp equal to POS_ACK SHALL increment pass_cnt; resp_rdy with any other byte SHALL increment fail_cnt.
REQ-026 In both cases of REQ-025, resp SHALL be latched into last_resp.
REQ-027 The timeout counter SHALL start at the SEND cycle.
REQ-028 If TMO_CYC cycles elapse in WAIT_SNT or WAIT_RESP without a qualifying resp_rdy, fail_cnt SHALL increment, tmo_err SHALL be set, and the command SHALL be retired.
REQ-029 After a command is retired, the FSM SHALL go to SEND if the queue is non-empty, else to DONE.
REQ-030 resp_rdy arriving in the same cycle the timeout expires SHALL count as a response, not a timeout.
REQ-031 resp_rdy while in WAIT_SNT SHALL be accepted as the response.
REQ-032 resp_rdy in IDLE, SEND or DONE SHALL be ignored.
REQ-033 DONE: done SHALL be 1 and busy SHALL be 0; start SHALL re-enter SEND if the queue is non-empty, else IDLE; clr_stat SHALL return the FSM to IDLE.
REQ-034 busy SHALL be 1 in SEND, WAIT_SNT and WAIT_RESP, and 0 otherwise.
REQ-035 start while busy SHALL be ignored.
REQ-036 push while full SHALL drop the word and set ovf_err; a push in the same cycle as a SEND pop when full SHALL be accepted.
REQ-037 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-038 Pushes SHALL be accepted in every state.
REQ-039 Read and write pointers SHALL wrap modulo DEPTH.
REQ-040 pass_cnt and fail_cnt SHALL saturate at all-ones.
REQ-041 clr_stat SHALL zero pass_cnt, fail_cnt, tmo_err, ovf_err and last_resp, and SHALL NOT affect queue contents.

Reset
REQ-042 On rst the block SHALL enter IDLE and empty the queue.
REQ-043 On rst, cmd, snd_cmd, counters, flags, done, busy and last_resp SHALL be 0; empty SHALL be 1 and full SHALL be 0.
REQ-044 rst asserted mid-sequence SHALL abandon the in-flight command without counting it.

Configuration
REQ-045 The macro MOVE_SEQ_STOP_ON_ERR_EN SHALL select the failure behaviour.
REQ-046 With MOVE_SEQ_STOP_ON_ERR_EN defined, any failure SHALL go directly to DONE, leaving the remaining commands queued.
REQ-047 Without MOVE_SEQ_STOP_ON_ERR_EN, the block SHALL continue through the whole queue.

Structure
REQ-048 A shared package ktour_pkg SHALL hold POS_ACK (8'hA5), the move-command opcode constants and the move_seq_state_t enum.
REQ-049 The queue SHALL be a sub-module cmd_fifo, parametrised by DEPTH and CMD_W, with push, pop, full, empty and head ports.

Verification
REQ-050 Reset, push 3 commands, start, RemoteComm model acks each with A5 -> snd_cmd pulses exactly 3 times, pass_cnt=3, fail_cnt=0, done=1, empty=1.
REQ-051 Push 1 command, start, model replies 8'h00 -> fail_cnt=1, last_resp=00, tmo_err=0.
REQ-052 TMO_CYC=100, model never responds -> fail_cnt increments exactly at cycle 100 after SEND, tmo_err=1; with MOVE_SEQ_STOP_ON_ERR_EN defined, the remaining commands stay queued.
REQ-053 Push DEPTH+1 words while idle -> full=1, ovf_err=1, the first DEPTH words are issued in push order.
REQ-054 rst asserted in WAIT_RESP -> next cycle the FSM is in IDLE, all counters are 0, empty=1, and no snd_cmd is issued.
REQ-055 resp_rdy coincident with timeout expiry -> the response is counted and tmo_err stays 0.

Source files
------------

// File: rtl/ktour_pkg.sv
// Shared definitions for the move sequencer: acknowledge byte, move opcodes,
// and the sequencer state encoding.
package ktour_pkg;

    localparam logic [7:0] POS_ACK = 8'hA5;

    // Move-command opcodes carried in the upper nibble of a command word
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_MOVE_N = 4'h1;
    localparam logic [3:0] OP_MOVE_S = 4'h2;
    localparam logic [3:0] OP_MOVE_E = 4'h3;
    localparam logic [3:0] OP_MOVE_W = 4'h4;
    localparam logic [3:0] OP_HOME   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_SNT,
        ST_WAIT_RESP,
        ST_DONE
    } move_seq_state_t;

    function automatic logic is_pos_ack(input logic [7:0] b);
        return b == POS_ACK;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command queue: head always presents the oldest word.
// A push while full is accepted only when a pop happens in the same cycle.
module cmd_fifo
    import ktour_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CMD_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CMD_W-1:0] din,
    input  logic             pop,
    output logic [CMD_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/move_seq.sv
// Issues queued move commands to RemoteComm one at a time and tallies the replies.
// Define MOVE_SEQ_STOP_ON_ERR_EN to halt in DONE on the first failed command.
module move_seq
    import ktour_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TMO_CYC = 30000000,
    parameter int CMD_W   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [CMD_W-1:0]                   push_cmd,
    input  logic                               start,
    input  logic                               clr_stat,
    output logic [CMD_W-1:0]                   cmd,
    output logic                               snd_cmd,
    input  logic                               cmd_snt,
    input  logic                               resp_rdy,
    input  logic [7:0]                         resp,
    output logic                               full,
    output logic                               empty,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(DEPTH+1)+8-1:0]       pass_cnt,
    output logic [$clog2(DEPTH+1)+8-1:0]       fail_cnt,
    output logic                               tmo_err,
    output logic                               ovf_err,
    output logic [7:0]                         last_resp
);

    localparam int CNT_W = $clog2(DEPTH + 1) + 8;
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    move_seq_state_t  state_reg;
    move_seq_state_t  state_next;
    move_seq_state_t  retire_dest;
    logic [CMD_W-1:0] head;
    logic [CMD_W-1:0] cmd_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [CNT_W-1:0] pass_cnt_reg;
    logic [CNT_W-1:0] fail_cnt_reg;
    logic             tmo_err_reg;
    logic             ovf_err_reg;
    logic [7:0]       last_resp_reg;
    logic             pop;
    logic             in_wait;
    logic             resp_take;
    logic             tmo_fire;
    logic             is_fail;
    logic             retire;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_cmd),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign pop       = (state_reg == ST_SEND);
    assign in_wait   = (state_reg == ST_WAIT_SNT) || (state_reg == ST_WAIT_RESP);
    assign resp_take = in_wait && resp_rdy;
    // A response in the expiry cycle wins over the timeout.
    assign tmo_fire  = in_wait && !resp_rdy && (tmo_cnt_reg == TMO_W'(TMO_CYC));
    assign is_fail   = tmo_fire || (resp_take && !is_pos_ack(resp));
    assign retire    = resp_take || tmo_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        retire_dest = empty ? ST_DONE : ST_SEND;
`ifdef MOVE_SEQ_STOP_ON_ERR_EN
        if (is_fail) begin
            retire_dest = ST_DONE;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && !empty) state_next = ST_SEND;
            end
            ST_SEND: begin
                state_next = ST_WAIT_SNT;
            end
            ST_WAIT_SNT: begin
                if (retire)       state_next = retire_dest;
                else if (cmd_snt) state_next = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (retire) state_next = retire_dest;
            end
            ST_DONE: begin
                if (clr_stat)   state_next = ST_IDLE;
                else if (start) state_next = empty ? ST_IDLE : ST_SEND;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        snd_cmd = (state_reg == ST_SEND);
        busy    = (state_reg == ST_SEND) || in_wait;
        done    = (state_reg == ST_DONE);
        cmd     = (state_reg == ST_SEND) ? head : cmd_reg;
    end

    // Cycle count since SEND: SEND loads 1, so expiry lands TMO_CYC cycles after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_reg     <= '0;
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_SEND) begin
            cmd_reg     <= head;
            tmo_cnt_reg <= TMO_W'(1);
        end else if (in_wait && (tmo_cnt_reg != TMO_W'(TMO_CYC))) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stat) begin
            pass_cnt_reg  <= '0;
            fail_cnt_reg  <= '0;
            tmo_err_reg   <= 1'b0;
            ovf_err_reg   <= 1'b0;
            last_resp_reg <= '0;
        end else begin
            if (resp_take) begin
                last_resp_reg <= resp;
            end
            if (resp_take && !is_fail && (pass_cnt_reg != '1)) begin
                pass_cnt_reg <= pass_cnt_reg + CNT_W'(1);
            end
            if (is_fail && (fail_cnt_reg != '1)) begin
                fail_cnt_reg <= fail_cnt_reg + CNT_W'(1);
            end
            if (tmo_fire) begin
                tmo_err_reg <= 1'b1;
            end
            if (push && full && !pop) begin
                ovf_err_reg <= 1'b1;
            end
        end
    end

    assign pass_cnt  = pass_cnt_reg;
    assign fail_cnt  = fail_cnt_reg;
    assign tmo_err   = tmo_err_reg;
    assign ovf_err   = ovf_err_reg;
    assign last_resp = last_resp_reg;

endmodule

// File: tb/tb_move_seq.sv
// Directed bench for move_seq with a scripted RemoteComm responder.
// Honours MOVE_SEQ_STOP_ON_ERR_EN for the timeout scenario.
module tb_move_seq;

    localparam int DEPTH   = 4;
    localparam int TMO_CYC = 100;
    localparam int CMD_W   = 16;
    localparam int CNT_W   = $clog2(DEPTH + 1) + 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic [CMD_W-1:0] push_cmd;
    logic             start;
    logic             clr_stat;
    logic [CMD_W-1:0] cmd;
    logic             snd_cmd;
    logic             cmd_snt;
    logic             resp_rdy;
    logic [7:0]       resp;
    logic             full;
    logic             empty;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             tmo_err;
    logic             ovf_err;
    logic [7:0]       last_resp;

    int errors    = 0;
    int checks    = 0;
    int snd_total = 0;
    int snd_base  = 0;
    bit ok;

    move_seq #(
        .DEPTH   (DEPTH),
        .TMO_CYC (TMO_CYC),
        .CMD_W   (CMD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_cmd  (push_cmd),
        .start     (start),
        .clr_stat  (clr_stat),
        .cmd       (cmd),
        .snd_cmd   (snd_cmd),
        .cmd_snt   (cmd_snt),
        .resp_rdy  (resp_rdy),
        .resp      (resp),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .tmo_err   (tmo_err),
        .ovf_err   (ovf_err),
        .last_resp (last_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (snd_cmd) snd_total <= snd_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [CMD_W-1:0] w);
        push     = 1'b1;
        push_cmd = w;
        tick();
        push     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
    endtask

    task automatic wait_snd(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (snd_cmd) found = 1'b1;
            else tick();
        end
        if (!found) check("snd_wait", 32'd0, 32'd1);
    endtask

    // Wait for the SEND, optionally push in that cycle, then cmd_snt followed by a reply.
    task automatic issue(input logic [CMD_W-1:0] exp_cmd, input logic [7:0] rbyte,
                         input bit push_in_send, input logic [CMD_W-1:0] pw);
        bit found;
        wait_snd(found);
        if (found) begin
            check("cmd", 32'(cmd), 32'(exp_cmd));
            if (push_in_send) begin
                push     = 1'b1;
                push_cmd = pw;
            end
            tick();
            push = 1'b0;
            if (push_in_send) check("full_on_push_pop", 32'(full), 32'd1);
            check("busy_wait", 32'(busy), 32'd1);
            cmd_snt = 1'b1;
            tick();
            cmd_snt  = 1'b0;
            resp_rdy = 1'b1;
            resp     = rbyte;
            tick();
            resp_rdy = 1'b0;
            $display("txn cmd=%h resp=%h pass=%0d fail=%0d", exp_cmd, rbyte, pass_cnt, fail_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; push_cmd = '0; start = 1'b0; clr_stat = 1'b0;
        cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_snd", 32'(snd_cmd), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cnts", 32'({pass_cnt, fail_cnt}), 32'd0);
        check("rst_flags", 32'({tmo_err, ovf_err}), 32'd0);
        check("rst_last", 32'(last_resp), 32'd0);

        // Start with an empty queue is ignored
        pulse_start();
        check("start_empty", 32'(busy), 32'd0);

        // Three commands, all acknowledged
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        snd_base = snd_total;
        pulse_start();
        issue(16'h1111, 8'hA5, 1'b0, '0);
        issue(16'h2222, 8'hA5, 1'b0, '0);
        issue(16'h3333, 8'hA5, 1'b0, '0);
        check("three_snd", 32'(snd_total - snd_base), 32'd3);
        check("three_pass", 32'(pass_cnt), 32'd3);
        check("three_fail", 32'(fail_cnt), 32'd0);
        check("three_done", 32'(done), 32'd1);
        check("three_busy", 32'(busy), 32'd0);
        check("three_empty", 32'(empty), 32'd1);
        check("three_last", 32'(last_resp), 32'hA5);

        // Negative reply
        pulse_clr();
        check("clr_pass", 32'(pass_cnt), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        push_word(16'h4444);
        pulse_start();
        issue(16'h4444, 8'h00, 1'b0, '0);
        check("nak_fail", 32'(fail_cnt), 32'd1);
        check("nak_pass", 32'(pass_cnt), 32'd0);
        check("nak_last", 32'(last_resp), 32'h00);
        check("nak_tmo", 32'(tmo_err), 32'd0);

        // Silent responder: timeout lands exactly TMO_CYC cycles after SEND
        pulse_clr();
        push_word(16'h5555);
        push_word(16'h6666);
        pulse_start();
        wait_snd(ok);
        check("tmo_cmd", 32'(cmd), 32'h5555);
        repeat (TMO_CYC) tick();
        check("tmo_before_fail", 32'(fail_cnt), 32'd0);
        check("tmo_before_flag", 32'(tmo_err), 32'd0);
        tick();
        check("tmo_fail", 32'(fail_cnt), 32'd1);
        check("tmo_flag", 32'(tmo_err), 32'd1);
`ifdef MOVE_SEQ_STOP_ON_ERR_EN
        check("tmo_stop_done", 32'(done), 32'd1);
        check("tmo_stop_queued", 32'(empty), 32'd0);
        pulse_start();
`endif
        issue(16'h6666, 8'hA5, 1'b0, '0);
        check("tmo_after_pass", 32'(pass_cnt), 32'd1);
        check("tmo_after_done", 32'(done), 32'd1);

        // Response in the very cycle the timeout would expire (still in WAIT_SNT)
        pulse_clr();
        push_word(16'h7777);
        pulse_start();
        wait_snd(ok);
        repeat (TMO_CYC) tick();
        resp_rdy = 1'b1;
        resp     = 8'hA5;
        tick();
        resp_rdy = 1'b0;
        check("edge_pass", 32'(pass_cnt), 32'd1);
        check("edge_fail", 32'(fail_cnt), 32'd0);
        check("edge_tmo", 32'(tmo_err), 32'd0);
        check("edge_done", 32'(done), 32'd1);

        // Overflow: DEPTH+1 pushes, then a push accepted alongside the first pop
        pulse_clr();
        for (int i = 0; i <= DEPTH; i++) push_word(16'h8001 + 16'(i));
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(ovf_err), 32'd1);
        check("ovf_empty", 32'(empty), 32'd0);
        pulse_start();
        issue(16'h8001, 8'hA5, 1'b1, 16'h8006);
        issue(16'h8002, 8'hA5, 1'b0, '0);
        issue(16'h8003, 8'hA5, 1'b0, '0);
        issue(16'h8004, 8'hA5, 1'b0, '0);
        issue(16'h8006, 8'hA5, 1'b0, '0);
        check("ovf_pass", 32'(pass_cnt), 32'd5);
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_drained", 32'(empty), 32'd1);

        // Reset while waiting for the response
        push_word(16'h9001);
        push_word(16'h9002);
        pulse_start();
        wait_snd(ok);
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy_after", 32'(busy), 32'd0);
        check("mid_done_after", 32'(done), 32'd0);
        check("mid_cnts", 32'({pass_cnt, fail_cnt}), 32'd0);
        check("mid_flags", 32'({tmo_err, ovf_err}), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_cmd", 32'(cmd), 32'd0);
        snd_base = snd_total;
        repeat (10) tick();
        check("mid_no_snd", 32'(snd_total - snd_base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
